// File: rtl/mod_correct_serial.sv
// Word-serial modular correction: x-m if x>=m (mode 0) or x+m if x<0 (mode 1), LSW first.
// Latency NWORDS+1 cycles start-to-done; no backpressure, start is ignored unless idle.
module mod_correct_serial #(
   parameter int DATA_W = 1027,
   parameter int WORD_W = 64,
   parameter int NWORDS = (DATA_W + WORD_W) / WORD_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W:0]   in_x,
   input  logic [DATA_W-1:0] in_m,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              done
);

   localparam int TOT_W = NWORDS * WORD_W;
   localparam int CNT_W = $clog2(NWORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_SELECT} state_t;

   state_t              state_q, state_d;
   logic [TOT_W-1:0]    x_q, x_d;
   logic [TOT_W-1:0]    m_q, m_d;
   logic [TOT_W-1:0]    diff_q, diff_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mode_q, mode_d;
   logic                cy_q, cy_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                done_q, done_d;

   logic [WORD_W-1:0]   x_w, m_w;
   logic [WORD_W:0]     sum_w;
   logic                take_diff;

   assign x_w = x_q[WORD_W-1:0];
   assign m_w = m_q[WORD_W-1:0];

   // Top bit of the (WORD_W+1)-bit result is carry-out in mode 1 and borrow-out in mode 0.
   assign sum_w = mode_q ? ({1'b0, x_w} + {1'b0, m_w} + {{WORD_W{1'b0}}, cy_q})
                         : ({1'b0, x_w} - {1'b0, m_w} - {{WORD_W{1'b0}}, cy_q});

   assign take_diff = mode_q ? x_q[DATA_W] : ~cy_q;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      m_d      = m_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      cy_d     = cy_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = {{(TOT_W-DATA_W-1){1'b0}}, in_x};
               m_d     = {{(TOT_W-DATA_W){1'b0}}, in_m};
               mode_d  = mode;
               cy_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // x rotates rather than shifting out, so after NWORDS words it is intact for bypass.
            x_d    = {x_w, x_q[TOT_W-1:WORD_W]};
            m_d    = {{WORD_W{1'b0}}, m_q[TOT_W-1:WORD_W]};
            diff_d = {sum_w[WORD_W-1:0], diff_q[TOT_W-1:WORD_W]};
            cy_d   = sum_w[WORD_W];
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NWORDS - 1)) begin
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            result_d = take_diff ? diff_q[DATA_W-1:0] : x_q[DATA_W-1:0];
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         m_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         cy_q     <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         m_q      <= m_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         cy_q     <= cy_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mod_correct_serial.sv
// Scoreboard bench for mod_correct_serial: driver queues expected results, monitor checks on done.
module tb_mod_correct_serial;

   localparam int DW = 1027;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic          mode;
   logic [DW:0]   in_x;
   logic [DW-1:0] in_m;
   logic [DW-1:0] result;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   mod_correct_serial dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .mode   (mode),
      .in_x   (in_x),
      .in_m   (in_m),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   typedef struct {
      string         tag;
      logic [DW-1:0] res;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   passes = 0;
   int   total  = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act === req) passes++;
      else $display("FAIL %s: actual top=%0h low=%h required top=%0h low=%h",
                    name, act[DW-1:DW-3], act[95:0], req[DW-1:DW-3], req[95:0]);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: actual done=1 at cycle %0d required no done", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_result"}, result, e.res);
            chk({e.tag, "_latency"}, DW'(cyc), DW'(e.cyc));
         end
      end
   end

   // Called at a negedge; start is sampled on the following posedge.
   task automatic issue(input string tag, input logic md, input logic [DW:0] x,
                        input logic [DW-1:0] m, input logic [DW-1:0] exp_res, input bit push);
      exp_t e;
      mode  = md;
      in_x  = x;
      in_m  = m;
      start = 1'b1;
      if (push) begin
         e.tag = tag;
         e.res = exp_res;
         e.cyc = cyc + 19;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      in_x  = ~x;
      in_m  = m ^ 1027'h5;
      mode  = ~md;
      chk({tag, "_busy"}, DW'(busy), DW'(1));
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL drain: actual %0d results pending required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW:0]   xa;
      logic [DW-1:0] ma, ea;
      int            n;

      resetn = 1'b0;
      start  = 1'b0;
      mode   = 1'b0;
      in_x   = '0;
      in_m   = '0;
      repeat (3) @(negedge clk);
      chk("reset_result", result, '0);
      chk("reset_busy", DW'(busy), DW'(0));
      chk("reset_done", DW'(done), DW'(0));
      resetn = 1'b1;
      @(negedge clk);

      // Mode 0, m = 13
      issue("m0_x20", 1'b0, 1028'd20, 1027'd13, 1027'd7, 1'b1);  drain();
      issue("m0_x12", 1'b0, 1028'd12, 1027'd13, 1027'd12, 1'b1); drain();
      issue("m0_x13", 1'b0, 1028'd13, 1027'd13, 1027'd0, 1'b1);  drain();
      issue("m0_x0",  1'b0, 1028'd0,  1027'd13, 1027'd0, 1'b1);  drain();

      // Mode 1, m = 13
      xa = '0 - 1028'd5;
      issue("m1_xn5", 1'b1, xa, 1027'd13, 1027'd8, 1'b1);        drain();
      issue("m1_x5",  1'b1, 1028'd5, 1027'd13, 1027'd5, 1'b1);   drain();
      xa = '0 - 1028'd1;
      issue("m1_xn1", 1'b1, xa, 1027'd13, 1027'd12, 1'b1);       drain();
      issue("m1_x0",  1'b1, 1028'd0, 1027'd13, 1027'd0, 1'b1);   drain();

      // Wide operands
      ma = (1027'd1 << 1026) + 1027'd1;
      xa = (1028'd1 << 1027) + 1028'd1;
      ea = 1027'd1 << 1026;
      issue("m0_top", 1'b0, xa, ma, ea, 1'b1);                    drain();
      ma = 1027'd1 << 64;
      xa = (1028'd1 << 64) + 1028'd3;
      issue("m0_w64", 1'b0, xa, ma, 1027'd3, 1'b1);               drain();
      ma = (1027'd1 << 64) + 1027'd5;
      xa = (1028'd1 << 65) + 1028'd2;
      ea = (1027'd1 << 64) - 1027'd3;
      issue("m0_borrow", 1'b0, xa, ma, ea, 1'b1);                 drain();
      ma = (1027'd1 << 1026) + 1027'd1;
      xa = '0 - (1028'd1 << 64);
      ea = (1027'd1 << 1026) - (1027'd1 << 64) + 1027'd1;
      issue("m1_carry", 1'b1, xa, ma, ea, 1'b1);                  drain();

      // Back-to-back: second start asserted in the done cycle of the first
      xa = '0 - 1028'd1;
      issue("b2b_a", 1'b1, xa, 1027'd13, 1027'd12, 1'b1);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total++;
         $display("FAIL b2b_wait: actual no done within 40 cycles required done");
      end
      issue("b2b_b", 1'b0, 1028'd20, 1027'd13, 1027'd7, 1'b1);
      drain();

      // Start while busy is ignored
      issue("ign_a", 1'b0, 1028'd25, 1027'd13, 1027'd12, 1'b1);
      repeat (4) @(negedge clk);
      issue("ign_b", 1'b1, 1028'd3, 1027'd11, 1027'd0, 1'b0);
      drain();
      repeat (25) @(negedge clk);
      chk("ign_hold", result, 1027'd12);

      // Reset mid-RUN aborts without a done pulse
      issue("rst_op", 1'b0, 1028'd20, 1027'd13, 1027'd7, 1'b0);
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_result", result, '0);
      chk("rst_mid_busy", DW'(busy), DW'(0));
      chk("rst_mid_done", DW'(done), DW'(0));
      resetn = 1'b1;
      repeat (30) @(negedge clk);
      chk("rst_after_busy", DW'(busy), DW'(0));
      chk("rst_after_result", result, '0);
      issue("post_rst", 1'b0, 1028'd20, 1027'd13, 1027'd7, 1'b1);
      drain();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
